// File: rtl/io_event_fifo.sv
// io_event_fifo: synchronises and debounces WIDTH input pins and queues each
// debounced change as one sample in a DEPTH-entry first-word-fall-through FIFO.
// Ports: clk, rst (sync, active-high), in_pins[WIDTH], rd_en, clr_ovf in;
//        data_out[DATA_W], valid, count[$clog2(DEPTH)+1], overflow (sticky) out.
// Option: define IO_TIMESTAMP_EN to store {cycle counter, sample} per entry.
module io_event_fifo #(
  parameter int WIDTH       = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_pins,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
`ifdef IO_TIMESTAMP_EN
  localparam int TS_W = DATA_W - WIDTH;
  localparam int EW   = DATA_W;
`else
  localparam int EW   = WIDTH;
`endif

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] sync_d;
  logic [WIDTH-1:0] stable;
  logic [CW-1:0]    cnt;
  logic             accept;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    entry;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             wr;
  logic             ovf_set;

  // Synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_pins;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // A change is accepted once sync has held a new value for DEBOUNCE
  // consecutive comparisons against its previous-cycle value.
  assign accept = (sync != stable) && (sync == sync_d) &&
                  (cnt == CW'(DEBOUNCE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_d <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync_d <= sync;
      if (accept) begin
        stable <= sync;
        cnt    <= '0;
      end else if (sync == stable || sync != sync_d) begin
        cnt    <= '0;
      end else begin
        cnt    <= cnt + CW'(1);
      end
    end
  end

`ifdef IO_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_W'(1);
  end

  assign entry = {ts, sync};
`else
  assign entry = sync;
`endif

  // FIFO control; a pop frees the head slot so a full FIFO can still
  // take a simultaneous push without dropping it.
  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = rd_en & valid;
  assign wr      = accept & (~full | pop);
  assign ovf_set = accept & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign data_out = valid ? DATA_W'(mem[rd_ptr]) : '0;

endmodule

// File: tb/tb_io_event_fifo.sv
// tb_io_event_fifo: directed and randomized checks of io_event_fifo against
// a pin-history / queue reference model.
module tb_io_event_fifo;
  localparam int DEPTH = 4;
  localparam int DB    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_pins = '0;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [15:0] data_out;
  logic        valid;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_event_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .in_pins  (in_pins),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .data_out (data_out),
    .valid    (valid),
    .count    (count),
    .overflow (overflow)
  );

  // Reference model: pin/reset history per edge, sample queue, sticky flag.
  logic [7:0] p_h [16];
  bit         r_h [16];
  int         n = 0;
  logic [7:0] q [$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_stable = '0;

  // Synchronised pin value seen just before edge k: pins two edges back,
  // or 0 if either of the two intervening edges was a reset.
  function automatic logic [7:0] s_at(int k);
    if (k < 2) return 8'h00;
    if (r_h[(k-1) & 15] || r_h[(k-2) & 15]) return 8'h00;
    return p_h[(k-2) & 15];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(bit r, logic [7:0] pv, bit rd, bit clr);
    logic [7:0] sv;
    bit acc;
    bit ovs;
    rst = r;
    in_pins = pv;
    rd_en = rd;
    clr_ovf = clr;
    p_h[n & 15] = pv;
    r_h[n & 15] = r;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_stable = '0;
    end else begin
      sv  = s_at(n);
      acc = (sv != m_stable);
      for (int k = n - DB; k < n; k++)
        if (s_at(k) != sv) acc = 0;
      ovs = 0;
      if (rd && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        if (q.size() < DEPTH) q.push_back(sv);
        else ovs = 1;
        m_stable = sv;
      end
      if (ovs) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    n++;
    #1;
    chk("valid", valid, (q.size() > 0));
    chk("data_out", data_out, (q.size() > 0) ? {24'h0, q[0]} : 32'h0);
    chk("count", count, q.size());
    chk("overflow", overflow, m_ovf);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      p_h[i] = '0;
      r_h[i] = 1'b1;
    end

    // Reset with all pins high, then release
    repeat (3) tick(1, 8'hFF, 0, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_count", count, 0);
    repeat (6) tick(0, 8'hFF, 0, 0);
    chk("lat_valid_early", valid, 0);
    tick(0, 8'hFF, 0, 0);
    chk("lat_data", data_out, 32'h00FF);
    tick(0, 8'hFF, 1, 0);

    // Back to idle, then a 2-cycle glitch on pin 3
    repeat (8) tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 1, 0);
    repeat (2) tick(0, 8'h08, 0, 0);
    repeat (8) tick(0, 8'h00, 0, 0);
    chk("glitch_valid", valid, 0);
    chk("glitch_count", count, 0);

    // Single change and pop
    repeat (10) tick(0, 8'h12, 0, 0);
    chk("one_data", data_out, 32'h0012);
    chk("one_count", count, 1);
    tick(0, 8'h12, 1, 0);
    chk("pop_valid", valid, 0);
    chk("pop_data", data_out, 0);

    // Five changes into a 4-deep FIFO
    for (int v = 1; v <= 5; v++)
      repeat (8) tick(0, 8'(v), 0, 0);
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    for (int v = 1; v <= 4; v++) begin
      chk("ovf_order", data_out, v);
      tick(0, 8'h05, 1, 0);
    end
    tick(0, 8'h05, 0, 1);
    chk("ovf_clear", overflow, 0);

    // Full FIFO, push coincides with pop
    for (int v = 6; v <= 9; v++)
      repeat (8) tick(0, 8'(v), 0, 0);
    chk("full_count", count, 4);
    repeat (6) tick(0, 8'h0A, 0, 0);
    tick(0, 8'h0A, 1, 0);
    chk("pp_count", count, 4);
    chk("pp_head", data_out, 32'h0007);
    chk("pp_ovf", overflow, 0);

    // Randomized phase
    for (int g = 0; g < 120; g++) begin
      logic [7:0] v;
      int len;
      v   = 8'($urandom_range(0, 255));
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++)
        tick($urandom_range(0, 199) == 0, v,
             (g < 60) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0),
             $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
